// File: rtl/uart_recv.sv
// 8N1 UART receiver with 2-FF input synchronizer and 3-sample majority vote.
// Bit period is chosen per frame from baud and held until the frame ends.
module uart_recv (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic [2:0] baud,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       rx_state,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic        rx_meta_q;
  logic        rx_s_q;
  logic        rx_prev_q;
  logic [1:0]  fill_q, fill_d;
  logic        arm_q, arm_d;
  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [12:0] t_q, t_d;
  logic [1:0]  v_q, v_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [12:0] t_sel;
  logic [12:0] h;
  logic [12:0] h_m1;
  logic [12:0] h_p1;
  logic        start_edge;
  logic        vote;
  logic        wrap;
  logic        at_vote;

  always_comb begin
    case (baud)
      3'd1:    t_sel = 13'd2603;
      3'd2:    t_sel = 13'd1301;
      3'd3:    t_sel = 13'd867;
      3'd4:    t_sel = 13'd433;
      default: t_sel = 13'd5207;
    endcase
  end

  assign h       = {1'b0, t_q[12:1]};
  assign h_m1    = h - 13'd1;
  assign h_p1    = h + 13'd1;
  assign wrap    = (cnt_q == t_q);
  assign at_vote = (cnt_q == h_p1);
  assign vote    = (v_q[0] & v_q[1])
                 | (v_q[0] & rx_s_q)
                 | (v_q[1] & rx_s_q);

  // Edges count only once a real high has come out of the synchronizer,
  // so a line held low through reset cannot fake a start bit.
  assign fill_d     = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
  assign arm_d      = arm_q | ((fill_q == 2'd2) & rx_s_q);
  assign start_edge = arm_q & rx_prev_q & ~rx_s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    v_d     = v_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = wrap ? 13'd0 : cnt_q + 13'd1;
      if (cnt_q == h_m1) v_d[0] = rx_s_q;
      if (cnt_q == h)    v_d[1] = rx_s_q;
    end
    unique case (state_q)
      IDLE: begin
        cnt_d = 13'd0;
        if (start_edge) begin
          state_d = START;
          t_d     = t_sel;
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
          cnt_d   = 13'd0;
        end else if (wrap) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (at_vote) shift_d = {vote, shift_q[7:1]};
        if (wrap) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (at_vote) begin
          state_d = IDLE;
          cnt_d   = 13'd0;
          if (vote) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      fill_q    <= 2'd0;
      arm_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= 13'd0;
      t_q       <= 13'd5207;
      v_q       <= 2'b00;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      fill_q    <= fill_d;
      arm_q     <= arm_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      v_q       <= v_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign data      = data_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;
  assign rx_state  = (state_q != IDLE);

endmodule
